// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch/PC stage of the 16-bit core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Fetch-stage sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Branch condition codes carried in instr[11:9]
    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Word-granular PC-relative offset: sign-extend the 9-bit immediate, scale by 2
    function automatic logic [15:0] br_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle of fetch-stage signals: imem port, decode handshake, flag update, status.
// Latency: n/a (wiring only).
// Backpressure: stall from the data side holds EXEC; imem_ready gates FETCH.
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        branch;
    logic        branch_reg;
    logic        halt;
    logic [15:0] rs_data;
    logic [2:0]  flag_we;
    logic [2:0]  flag_in;
    logic        stall;
    logic        branch_taken;
    logic        halted;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus2,
               branch_taken, halted,
        input  imem_rdata, imem_ready, branch, branch_reg, halt, rs_data,
               flag_we, flag_in, stall
    );

    // Memory / decode / datapath side
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus2,
               branch_taken, halted,
        output imem_rdata, imem_ready, branch, branch_reg, halt, rs_data,
               flag_we, flag_in, stall
    );
endinterface

// File: rtl/fetch_pc_unit_branch_cond.sv
// Evaluates a branch condition code against the {Z,V,N} flags.
// Latency: combinational.
// Backpressure: none.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] i_cc,
    input  logic [2:0] i_flags,
    output logic       o_cond_met
);
    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = i_flags[FLAG_Z];
    assign w_v = i_flags[FLAG_V];
    assign w_n = i_flags[FLAG_N];

    // Condition table; GE is "equal or greater", which reduces to Z | ~N
    always_comb begin
        o_cond_met = 1'b0;
        case (i_cc)
            CC_NE:   o_cond_met = !w_z;
            CC_EQ:   o_cond_met = w_z;
            CC_GT:   o_cond_met = !w_z && !w_n;
            CC_LT:   o_cond_met = w_n;
            CC_GE:   o_cond_met = w_z || !w_n;
            CC_LE:   o_cond_met = w_n || w_z;
            CC_OV:   o_cond_met = w_v;
            default: o_cond_met = 1'b1;
        endcase
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch + program counter: fetches at pc, presents instr to decode, picks next pc.
// Latency: 2 cycles/instruction minimum (FETCH + EXEC); +1 per imem wait cycle, +1 per stall cycle.
// Backpressure: imem_ready low extends FETCH; stall high freezes EXEC (pc and flags held).
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.master bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [2:0]  r_flags;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_pc_nxt;
    logic        w_cond_met;
    logic        w_taken;
    logic        w_exec_go;

    branch_cond u_branch_cond (
        .i_cc       (r_instr[11:9]),
        .i_flags    (r_flags),
        .o_cond_met (w_cond_met)
    );

    assign w_exec_go  = (r_state == ST_EXEC) && !bus.stall;
    assign w_pc_plus2 = r_pc + 16'd2;
    // Halt overrides a simultaneous branch, so no target is ever reported with it
    assign w_taken    = (r_state == ST_EXEC) && bus.branch && !bus.halt && w_cond_met;

    // Next-PC mux: register target, PC-relative target, or fall-through
    always_comb begin
        w_pc_nxt = w_pc_plus2;
        if (w_taken) begin
            if (bus.branch_reg) begin
                w_pc_nxt = bus.rs_data;
            end else begin
                w_pc_nxt = w_pc_plus2 + br_offset(r_instr[8:0]);
            end
        end
    end

    // Next-state logic for the fetch sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH:  if (bus.imem_ready) w_state_nxt = ST_EXEC;
            ST_EXEC:   if (!bus.stall) w_state_nxt = bus.halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // PC advances only when EXEC completes without a halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_pc <= RESET_PC;
        else if (w_exec_go && !bus.halt) r_pc <= w_pc_nxt;
    end

    // Instruction latch, loaded on the FETCH edge that sees memory ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_instr <= 16'h0000;
        else if ((r_state == ST_FETCH) && bus.imem_ready) r_instr <= bus.imem_rdata;
    end

    // Flags update per-bit; the branch above already saw the pre-edge values
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_flags <= 3'b000;
        else if (w_exec_go) r_flags <= (r_flags & ~bus.flag_we) | (bus.flag_in & bus.flag_we);
    end

    assign bus.imem_req     = (r_state == ST_FETCH);
    assign bus.imem_addr    = r_pc;
    assign bus.instr        = r_instr;
    assign bus.instr_valid  = (r_state == ST_EXEC);
    assign bus.pc           = r_pc;
    assign bus.pc_plus2     = w_pc_plus2;
    assign bus.branch_taken = w_taken;
    assign bus.halted       = (r_state == ST_HALTED);
endmodule
